hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Hazard and forwarding controller for the 16-bit pipelined core.
//  - Tracks destination tags of in-flight instructions in EX, MEM and WB.
//  - Drives the one-hot operand-forwarding selects (fwd_A/fwd_B) consumed by the EX-stage datapath.
//  - Detects load-use hazards: stalls IF/ID and injects a bubble into ID/EX.
//  - Squashes ID/EX on a pipeline flush and counts stall cycles for performance monitoring.
// PARAMETERS
//  REG_W  3   register-address width (8 architectural registers)
//  CNT_W  16  stall-cycle counter width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  id_valid     in   1      ID stage holds a real instruction
//  id_rn        in   REG_W  ID source A register (Rn)
//  id_rm        in   REG_W  ID source B register (Rm)
//  id_use_rn    in   1      ID instr reads Rn (0 when asel forces A=0)
//  id_use_rm    in   1      ID instr reads Rm (0 when bsel/imm_sel selects an immediate)
//  id_wr        in   1      ID instr writes a register
//  id_rd        in   REG_W  ID destination register
//  id_is_load   in   1      ID instr is a memory load (result valid only in WB)
//  flush        in   1      squash instr entering EX (taken branch resolved)
//  fwd_A        out  3      EX select, A operand: 100=wb_data, 010=regfile/a_in, 001=mem_data
//  fwd_B        out  3      EX select, B operand: same one-hot encoding as fwd_A
//  stall        out  1      hold PC and IF/ID this cycle (combinational)
//  bubble       out  1      load NOP into ID/EX this cycle (combinational; equals stall)
//  stall_count  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - ex/mem/wb valid tags = 0.
//   - fwd_A = fwd_B = 3'b010.
//   - stall_count = 0.
//   - stall = bubble = 0 while in reset.
//  Tag pipeline, each clk edge:
//   - wb <= mem; mem <= ex.
//   - ex <= {id_valid,id_wr,id_rd,id_is_load}, or invalid if bubble|flush.
//  A tag matches source s when: valid & wr & rd==s & use_s.
//  Load-use hazard (comb):
//   - Condition: id_valid & ex tag is a load & ex matches id_rn or id_rm.
//   - Action: stall = bubble = 1, unless flush=1, in which case both = 0.
//  Next-fwd per operand for the ID instr (registered into fwd_A/fwd_B at the edge):
//   - ex match (non-load) -> 001 (producer will be in MEM).
//   - else mem match (any, incl. load) -> 100 (producer will be in WB).
//   - else -> 010.
//   - ex match has priority over mem match (youngest producer wins).
//  fwd_A/fwd_B <= 010 when bubble|flush|~id_valid, or when the operand is unused.
//  Latency: fwd values are valid in the same cycle the instruction sits in EX (1 cycle after ID).
//  Register file:
//   - Written at the WB edge; readable by ID in the next cycle.
//   - No forwarding from a retired WB slot.
//  One-hot invariant: fwd_A/fwd_B never encode more than one bit.
//  stall_count:
//   - +1 on every cycle with stall=1.
//   - Holds at all-ones (no wrap).
//  Simultaneous flush and hazard: flush wins; no stall; EX tag invalidated.
//  Reset mid-stall: stall drops immediately (async); pipeline tags cleared.
// TESTING
//  1. Reset: rst_n=0 -> fwd_A=fwd_B=010, stall=0, stall_count=0.
//  2. EX->EX forward: ADD r1 then ADD r2,r1,r3 back-to-back -> 2nd instr in EX sees fwd_A=001.
//  3. Distance-2 forward: r1 producer, 1 independent instr, then r1 read on Rm -> fwd_B=100.
//  4. Priority: r1 written twice in a row, then r1 read -> fwd_A=001 (youngest), not 100.
//  5. Load-use: LDR r4 then ADD r5,r4,r4:
//     - 1-cycle stall; stall_count 0->1.
//     - ADD then reaches EX with fwd_A=fwd_B=100.
//  6. Flush: load-use hazard coincident with flush=1 -> stall=0, next fwd=010, stall_count unchanged.
//     Counter saturation with CNT_W=2 -> stalls 3,4,5 read 3.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller: tracks in-flight destination tags, drives the one-hot
// EX operand selects, detects load-use hazards and counts stall cycles.
module hazard_fwd_unit #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    input  logic             id_wr_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_is_load_i,
    input  logic             flush_i,
    output logic [2:0]       fwd_a_o,
    output logic [2:0]       fwd_b_o,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_count_o
);

    localparam logic [2:0] FwdWb  = 3'b100;
    localparam logic [2:0] FwdReg = 3'b010;
    localparam logic [2:0] FwdMem = 3'b001;

    // The WB slot is never a forwarding source (the register file covers it), so only the
    // EX and MEM tags are kept.
    logic             ex_valid_q, ex_valid_d;
    logic             ex_wr_q, ex_wr_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_valid_q;
    logic             mem_wr_q;
    logic [REG_W-1:0] mem_rd_q;

    logic [2:0]       fwd_a_q, fwd_a_d;
    logic [2:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic ex_match_rn, ex_match_rm;
    logic mem_match_rn, mem_match_rm;
    logic hazard, stall;

    always_comb begin
        ex_match_rn  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rn_i) & id_use_rn_i;
        ex_match_rm  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rm_i) & id_use_rm_i;
        mem_match_rn = mem_valid_q & mem_wr_q & (mem_rd_q == id_rn_i) & id_use_rn_i;
        mem_match_rm = mem_valid_q & mem_wr_q & (mem_rd_q == id_rm_i) & id_use_rm_i;
        hazard       = id_valid_i & ex_load_q & (ex_match_rn | ex_match_rm);
        stall        = hazard & ~flush_i;
    end

    always_comb begin
        ex_valid_d = id_valid_i & ~stall & ~flush_i;
        ex_wr_d    = id_wr_i;
        ex_rd_d    = id_rd_i;
        ex_load_d  = id_is_load_i;

        // Youngest producer wins: an EX match overrides a MEM match.
        fwd_a_d = FwdReg;
        fwd_b_d = FwdReg;
        if (ex_valid_d) begin
            if (ex_match_rn && !ex_load_q) begin
                fwd_a_d = FwdMem;
            end else if (mem_match_rn) begin
                fwd_a_d = FwdWb;
            end
            if (ex_match_rm && !ex_load_q) begin
                fwd_b_d = FwdMem;
            end else if (mem_match_rm) begin
                fwd_b_d = FwdWb;
            end
        end

        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q    <= 1'b0;
            ex_wr_q       <= 1'b0;
            ex_rd_q       <= '0;
            ex_load_q     <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= '0;
            fwd_a_q       <= FwdReg;
            fwd_b_q       <= FwdReg;
            stall_count_q <= '0;
        end else begin
            mem_valid_q   <= ex_valid_q;
            mem_wr_q      <= ex_wr_q;
            mem_rd_q      <= ex_rd_q;
            ex_valid_q    <= ex_valid_d;
            ex_wr_q       <= ex_wr_d;
            ex_rd_q       <= ex_rd_d;
            ex_load_q     <= ex_load_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_a_o       = fwd_a_q;
    assign fwd_b_o       = fwd_b_q;
    assign stall_o       = stall;
    assign bubble_o      = stall;
    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit; a second instance with a 2-bit counter checks
// saturation on the same stimulus.
module tb_hazard_fwd_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rn, id_rm, id_rd;
    logic        id_use_rn, id_use_rm, id_wr, id_is_load, flush;
    logic [2:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic        stall, bubble, stall_s, bubble_s;
    logic [15:0] stall_count;
    logic [1:0]  stall_count_s;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(.REG_W(3), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .id_valid_i   (id_valid),
        .id_rn_i      (id_rn),
        .id_rm_i      (id_rm),
        .id_use_rn_i  (id_use_rn),
        .id_use_rm_i  (id_use_rm),
        .id_wr_i      (id_wr),
        .id_rd_i      (id_rd),
        .id_is_load_i (id_is_load),
        .flush_i      (flush),
        .fwd_a_o      (fwd_a),
        .fwd_b_o      (fwd_b),
        .stall_o      (stall),
        .bubble_o     (bubble),
        .stall_count_o(stall_count)
    );

    hazard_fwd_unit #(.REG_W(3), .CNT_W(2)) dut_s (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .id_valid_i   (id_valid),
        .id_rn_i      (id_rn),
        .id_rm_i      (id_rm),
        .id_use_rn_i  (id_use_rn),
        .id_use_rm_i  (id_use_rm),
        .id_wr_i      (id_wr),
        .id_rd_i      (id_rd),
        .id_is_load_i (id_is_load),
        .flush_i      (flush),
        .fwd_a_o      (fwd_a_s),
        .fwd_b_o      (fwd_b_s),
        .stall_o      (stall_s),
        .bubble_o     (bubble_s),
        .stall_count_o(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rn, input logic [2:0] rm,
                          input logic urn, input logic urm, input logic wr,
                          input logic [2:0] rd, input logic ld, input logic fl);
        id_valid   = v;
        id_rn      = rn;
        id_rm      = rm;
        id_use_rn  = urn;
        id_use_rm  = urm;
        id_wr      = wr;
        id_rd      = rd;
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        repeat (2) step();
        total++;
        if (fwd_a !== 3'b010 || fwd_b !== 3'b010) begin
            bad++;
            $display("FAIL reset_fwd: got a=%b b=%b want a=010 b=010", fwd_a, fwd_b);
        end
        total++;
        if (stall !== 1'b0 || bubble !== 1'b0 || stall_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_stall: got stall=%b bubble=%b cnt=%0d want 0 0 0",
                     stall, bubble, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ex_fwd();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);  // ADD r1,r2,r3
        step();
        set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);  // ADD r2,r1,r3
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL ex_fwd_nostall: got stall=%b want 0", stall);
        end
        step();
        total++;
        if (fwd_a !== 3'b001 || fwd_b !== 3'b010) begin
            bad++;
            $display("FAIL ex_fwd: got a=%b b=%b want a=001 b=010", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_dist2();
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);  // MOV r1,#imm
        step();
        set_id(1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);  // ADD r5,r6,r7
        step();
        set_id(1'b1, 3'd3, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);  // ADD r2,r3,r1
        step();
        total++;
        if (fwd_a !== 3'b010 || fwd_b !== 3'b100) begin
            bad++;
            $display("FAIL dist2_fwd: got a=%b b=%b want a=010 b=100", fwd_a, fwd_b);
        end
        drain();
        // Same distance, but Rm replaced by an immediate: no forwarding.
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step();
        set_id(1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        step();
        total++;
        if (fwd_b !== 3'b010) begin
            bad++;
            $display("FAIL unused_operand: got b=%b want 010", fwd_b);
        end
        drain();
    endtask

    task automatic test_priority();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
        step();
        total++;
        if (fwd_a !== 3'b001 || fwd_b !== 3'b001) begin
            bad++;
            $display("FAIL priority: got a=%b b=%b want a=001 b=001", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);  // LDR r4,[r0]
        step();
        set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);  // ADD r5,r4,r4
        total++;
        if (stall !== 1'b1 || bubble !== 1'b1) begin
            bad++;
            $display("FAIL load_use_stall: got stall=%b bubble=%b want 1 1", stall, bubble);
        end
        step();
        total++;
        if (stall_count !== 16'd1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_count: got cnt=%0d stall=%b want 1 0", stall_count, stall);
        end
        total++;
        if (fwd_a !== 3'b010 || fwd_b !== 3'b010) begin
            bad++;
            $display("FAIL load_use_bubble_fwd: got a=%b b=%b want 010 010", fwd_a, fwd_b);
        end
        step();
        total++;
        if (fwd_a !== 3'b100 || fwd_b !== 3'b100 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL load_use_fwd: got a=%b b=%b cnt=%0d want 100 100 1",
                     fwd_a, fwd_b, stall_count);
        end
        drain();
    endtask

    task automatic test_flush();
        set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        step();
        set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1);
        total++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got stall=%b bubble=%b want 0 0", stall, bubble);
        end
        step();
        total++;
        if (fwd_a !== 3'b010 || fwd_b !== 3'b010 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL flush_fwd: got a=%b b=%b cnt=%0d want 010 010 1",
                     fwd_a, fwd_b, stall_count);
        end
        // EX was invalidated; the load is now in MEM so a reader forwards from WB.
        set_id(1'b1, 3'd4, 3'd2, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_ex_cleared: got stall=%b want 0", stall);
        end
        step();
        total++;
        if (fwd_a !== 3'b100 || fwd_b !== 3'b010) begin
            bad++;
            $display("FAIL flush_then_mem_fwd: got a=%b b=%b want 100 010", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int n = 2; n <= 5; n++) begin
            set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
            step();
            set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
            step();
            step();
            total++;
            if (stall_count_s !== 2'(n > 3 ? 3 : n) || stall_count !== 16'(n)) begin
                bad++;
                $display("FAIL saturation_%0d: got cnt2=%0d cnt16=%0d want %0d %0d",
                         n, stall_count_s, stall_count, (n > 3 ? 3 : n), n);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        step();
        set_id(1'b1, 3'd4, 3'd1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mid_stall_pre: got stall=%b want 1", stall);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || stall_count !== 16'd0 || fwd_a !== 3'b010) begin
            bad++;
            $display("FAIL mid_stall_reset: got stall=%b cnt=%0d a=%b want 0 0 010",
                     stall, stall_count, fwd_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (stall !== 1'b0 || fwd_a !== 3'b010) begin
            bad++;
            $display("FAIL mid_stall_after: got stall=%b a=%b want 0 010", stall, fwd_a);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_dist2();
        test_priority();
        test_load_use();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
